// File: rtl/fetch_decode_queue_pkg.sv
// Shared constants and types for the fetch/decode instruction queue.
// The HALT opcode test lives here so every user decodes it the same way.
package fetch_decode_queue_pkg;

    localparam logic [4:0]  OPC_HALT  = 5'b00000;
    localparam logic [15:0] INSTR_NOP = 16'h0800;
    localparam int          DEPTH     = 2;

    typedef enum logic [1:0] {
        RUN       = 2'b00,
        HALT_PEND = 2'b01,
        HALTED    = 2'b10
    } fdq_state_e;

    function automatic logic is_halt(input logic [15:0] instr);
        return instr[15:11] == OPC_HALT;
    endfunction

endpackage

// File: rtl/fetch_decode_queue_if.sv
// Fetch-side and decode-side handshake bundle of the instruction queue.
// slave is the queue's view; master is the view of the fetch/decode stages.
interface fetch_decode_queue_if;
    logic        fetch_valid;
    logic [15:0] instr_in;
    logic [15:0] pc_next_in;
    logic        fetch_ready;
    logic        dec_ready;
    logic        dec_valid;
    logic [15:0] instr_out;
    logic [15:0] pc_next_out;
    logic        flush;
    logic        halt_seen;

    modport slave (
        input  fetch_valid, instr_in, pc_next_in, dec_ready, flush,
        output fetch_ready, dec_valid, instr_out, pc_next_out, halt_seen
    );

    modport master (
        output fetch_valid, instr_in, pc_next_in, dec_ready, flush,
        input  fetch_ready, dec_valid, instr_out, pc_next_out, halt_seen
    );
endinterface

// File: rtl/register_16bits.sv
// Existing 16-bit storage register with synchronous reset and write enable.
module register_16bits (
    input  logic        clk,
    input  logic        rst,
    input  logic        writeEnable,
    input  logic [15:0] dataIn,
    output logic [15:0] dataOut
);
    always_ff @(posedge clk) begin
        if (rst)
            dataOut <= '0;
        else if (writeEnable)
            dataOut <= dataIn;
    end
endmodule

// File: rtl/fetch_decode_queue.sv
// Two-entry fetch->decode queue holding {pc_next, instruction}, with flush
// support and a halt state machine that stops fetch once HALT is enqueued.
module fetch_decode_queue
    import fetch_decode_queue_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    fetch_decode_queue_if.slave  q
);
    fdq_state_e                   state_q, state_d;
    logic                         wr_ptr, rd_ptr, halt_ptr;
    logic [1:0]                   count;
    logic [DEPTH-1:0][15:0]       instr_q;
    logic [DEPTH-1:0][15:0]       pc_q;
    logic                         push, pop;

    // Outputs decode only flops, so no input reaches an output combinationally.
    assign q.fetch_ready = (count != 2'd2) && (state_q == RUN);
    assign q.dec_valid   = (count != 2'd0);
    assign q.halt_seen   = (state_q == HALTED);
    assign q.instr_out   = q.dec_valid ? instr_q[rd_ptr] : INSTR_NOP;
    assign q.pc_next_out = q.dec_valid ? pc_q[rd_ptr]    : 16'h0000;

    // Flush squashes any same-cycle transfer.
    assign push = q.fetch_valid && q.fetch_ready && !q.flush;
    assign pop  = q.dec_valid   && q.dec_ready   && !q.flush;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        localparam logic IDX = 1'(i);
        logic wr_en;
        assign wr_en = push && (wr_ptr == IDX);

        register_16bits u_instr (
            .clk(clk), .rst(rst), .writeEnable(wr_en),
            .dataIn(q.instr_in), .dataOut(instr_q[i])
        );
        register_16bits u_pc (
            .clk(clk), .rst(rst), .writeEnable(wr_en),
            .dataIn(q.pc_next_in), .dataOut(pc_q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            halt_ptr <= 1'b0;
        end else if (q.flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (push && is_halt(q.instr_in)) halt_ptr <= wr_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:       if (push && is_halt(q.instr_in)) state_d = HALT_PEND;
            // A flush means the HALT sat on a squashed path.
            HALT_PEND: if (q.flush)                         state_d = RUN;
                       else if (pop && rd_ptr == halt_ptr)  state_d = HALTED;
            HALTED:    state_d = HALTED;
            default:   state_d = RUN;
        endcase
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench for fetch_decode_queue: accepted pushes are queued as
// expected decode output and compared against the head every cycle.
module tb_fetch_decode_queue;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_decode_queue_if bus();

    fetch_decode_queue dut (.clk(clk), .rst(rst), .q(bus));

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] sb[$];   // {pc_next, instr}
    int          m_st;    // 0 run, 1 halt pending, 2 halted

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic halt_op(input logic [15:0] ins);
        return ins[15:11] == 5'd0;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.fetch_valid = 1'b0; bus.dec_ready = 1'b0; bus.flush = 1'b0;
        bus.instr_in = '0; bus.pc_next_in = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        m_st = 0;
    endtask

    // Drive one cycle, check outputs against the model, then advance the model.
    task automatic step(input logic fv, input logic [15:0] ins, input logic [15:0] pc,
                        input logic dr, input logic fl);
        logic        e_rdy, e_vld, acc, deq;
        logic [31:0] head;
        bus.fetch_valid = fv; bus.instr_in = ins; bus.pc_next_in = pc;
        bus.dec_ready = dr; bus.flush = fl;
        @(negedge clk);
        e_rdy = (sb.size() < 2) && (m_st == 0);
        e_vld = (sb.size() != 0);
        head  = e_vld ? sb[0] : {16'h0000, 16'h0800};
        chk("fetch_ready", 16'(bus.fetch_ready), 16'(e_rdy));
        chk("dec_valid",   16'(bus.dec_valid),   16'(e_vld));
        chk("instr_out",   bus.instr_out,        head[15:0]);
        chk("pc_next_out", bus.pc_next_out,      head[31:16]);
        chk("halt_seen",   16'(bus.halt_seen),   16'(m_st == 2));
        acc = fv && e_rdy;
        deq = e_vld && dr;
        if (fl) begin
            sb.delete();
            if (m_st != 2) m_st = 0;
        end else begin
            if (deq) begin
                head = sb.pop_front();
                if (m_st == 1 && halt_op(head[15:0])) m_st = 2;
            end
            if (acc) begin
                sb.push_back({pc, ins});
                if (halt_op(ins)) m_st = 1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input logic dr);
        step(1'b0, 16'h0, 16'h0, dr, 1'b0);
    endtask

    initial begin
        do_reset();
        do_reset();
        chk("rst_ready", 16'(bus.fetch_ready), 16'd1);
        chk("rst_valid", 16'(bus.dec_valid), 16'd0);
        chk("rst_instr", bus.instr_out, 16'h0800);
        chk("rst_pc",    bus.pc_next_out, 16'h0000);
        idle(1'b0);

        // Fill with decode stalled; third push must be refused.
        step(1'b1, 16'h1234, 16'h0002, 1'b0, 1'b0);
        step(1'b1, 16'h5678, 16'h0004, 1'b0, 1'b0);
        chk("full_ready", 16'(bus.fetch_ready), 16'd0);
        step(1'b1, 16'h9ABC, 16'h0006, 1'b0, 1'b0);
        chk("drain0", bus.instr_out, 16'h1234);
        idle(1'b1);
        chk("drain1", bus.instr_out, 16'h5678);
        idle(1'b1);
        chk("drained", 16'(bus.dec_valid), 16'd0);
        idle(1'b1);

        // Streaming at one per cycle, wrapping pointers.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 16'h3000 + 16'(i), 16'h0100 + 16'(2 * i), 1'b1, 1'b0);
            chk("stream_lat", bus.instr_out, 16'h3000 + 16'(i));
        end
        idle(1'b1);
        idle(1'b1);

        // Full queue, then flush with push and pop in the same cycle.
        step(1'b1, 16'hA001, 16'h0200, 1'b0, 1'b0);
        step(1'b1, 16'hA002, 16'h0202, 1'b0, 1'b0);
        step(1'b1, 16'hA003, 16'h0204, 1'b1, 1'b1);
        chk("flush_valid", 16'(bus.dec_valid), 16'd0);
        chk("flush_instr", bus.instr_out, 16'h0800);
        chk("flush_ready", 16'(bus.fetch_ready), 16'd1);
        idle(1'b1);

        // HALT behind an ordinary instruction.
        step(1'b1, 16'h1111, 16'h0010, 1'b0, 1'b0);
        step(1'b1, 16'h0000, 16'h0012, 1'b0, 1'b0);
        chk("halt_ready", 16'(bus.fetch_ready), 16'd0);
        step(1'b1, 16'h4444, 16'h0014, 1'b1, 1'b0);
        chk("halt_head", bus.instr_out, 16'h0000);
        idle(1'b1);
        chk("halt_seen", 16'(bus.halt_seen), 16'd1);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        chk("halt_sticky", 16'(bus.halt_seen), 16'd1);
        step(1'b1, 16'h5555, 16'h0016, 1'b1, 1'b0);
        idle(1'b1);

        // HALT squashed by flush before decode takes it.
        do_reset();
        step(1'b1, 16'h0000, 16'h0020, 1'b0, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        chk("sq_ready", 16'(bus.fetch_ready), 16'd1);
        chk("sq_halt",  16'(bus.halt_seen), 16'd0);
        step(1'b1, 16'h6666, 16'h0022, 1'b1, 1'b0);
        idle(1'b1);

        // Reset while two entries wait in HALT_PEND.
        step(1'b1, 16'h1111, 16'h0030, 1'b0, 1'b0);
        step(1'b1, 16'h0000, 16'h0032, 1'b0, 1'b0);
        do_reset();
        chk("rst2_ready", 16'(bus.fetch_ready), 16'd1);
        chk("rst2_valid", 16'(bus.dec_valid), 16'd0);
        chk("rst2_instr", bus.instr_out, 16'h0800);
        chk("rst2_pc",    bus.pc_next_out, 16'h0000);
        chk("rst2_halt",  16'(bus.halt_seen), 16'd0);
        idle(1'b0);

        // Random traffic with rare flushes and occasional HALTs.
        for (int i = 0; i < 200; i++) begin
            logic [15:0] ins;
            ins = 16'($urandom) | 16'h8000;
            if ($urandom_range(0, 40) == 0) ins = 16'h0000;
            step(1'($urandom_range(0, 1)), ins, 16'($urandom),
                 1'($urandom_range(0, 2) != 0), $urandom_range(0, 15) == 0);
            if (m_st == 2 && $urandom_range(0, 3) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
